// File: rtl/lkt_lookup_arbiter.sv
// Round-robin arbiter sharing one lookup-table request port, with tag-based response routing and a
// credit limit on in-flight lookups. Define LKT_ARB_PERF_EN to add per-requester grant counters.
module lkt_lookup_arbiter #(
    parameter int NUM_LOOKUPS     = 4,
    parameter int KEY_WIDTH       = 32,
    parameter int RESULT_WIDTH    = 32,
    parameter int NUM_CHOICES     = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int TW = $clog2(NUM_LOOKUPS),
    localparam int CW = $clog2(NUM_CHOICES),
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_LOOKUPS-1:0]           req_valid,
    output logic [NUM_LOOKUPS-1:0]           req_ready,
    input  logic [NUM_LOOKUPS*KEY_WIDTH-1:0] req_key,
    output logic                             lkt_req_valid,
    input  logic                             lkt_req_ready,
    output logic [KEY_WIDTH-1:0]             lkt_req_key,
    output logic [TW-1:0]                    lkt_req_tag,
    input  logic                             lkt_rsp_valid,
    input  logic [TW-1:0]                    lkt_rsp_tag,
    input  logic                             lkt_rsp_hit,
    input  logic [CW-1:0]                    lkt_rsp_choice,
    input  logic [RESULT_WIDTH-1:0]          lkt_rsp_result,
    output logic [NUM_LOOKUPS-1:0]           rsp_valid,
    output logic                             rsp_hit,
    output logic [CW-1:0]                    rsp_choice,
    output logic [RESULT_WIDTH-1:0]          rsp_result,
    output logic [OW-1:0]                    outstanding,
    output logic                             err_unexp
`ifdef LKT_ARB_PERF_EN
    ,
    output logic [NUM_LOOKUPS*16-1:0]        grant_cnt
`endif
);

    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] scan_idx;
    logic [TW-1:0] grant_idx;
    logic          grant_found;
    logic          slot_free;
    logic          can_grant;
    logic          rsp_credit;

    assign slot_free  = !lkt_req_valid || lkt_req_ready;
    // rst_n gates the grant so req_ready reads 0 while reset is held, not just after it.
    assign can_grant  = rst_n && slot_free && (outstanding < MAX_OUT);
    assign rsp_credit = lkt_rsp_valid && (outstanding != '0);

    // NOTE: combinational scan uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        req_ready   = '0;
        for (int k = 0; k < NUM_LOOKUPS; k++) begin
            scan_idx = TW'((int'(rr_ptr) + k) % NUM_LOOKUPS);
            if (can_grant && !grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkt_req_valid <= 1'b0;
            lkt_req_key   <= '0;
            lkt_req_tag   <= '0;
            rr_ptr        <= '0;
        end else if (grant_found) begin
            lkt_req_valid <= 1'b1;
            lkt_req_key   <= req_key[int'(grant_idx)*KEY_WIDTH +: KEY_WIDTH];
            lkt_req_tag   <= grant_idx;
            rr_ptr        <= TW'((int'(grant_idx) + 1) % NUM_LOOKUPS);
        end else if (lkt_req_ready) begin
            lkt_req_valid <= 1'b0;
        end
    end

    // A response with no credit in use is flagged and never wraps the counter below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            err_unexp   <= 1'b0;
        end else begin
            if (lkt_rsp_valid && (outstanding == '0)) begin
                err_unexp <= 1'b1;
            end
            if (grant_found && !rsp_credit) begin
                outstanding <= outstanding + 1'b1;
            end else if (!grant_found && rsp_credit) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_hit    <= 1'b0;
            rsp_choice <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= '0;
            if (lkt_rsp_valid) begin
                if (int'(lkt_rsp_tag) < NUM_LOOKUPS) begin
                    rsp_valid[lkt_rsp_tag] <= 1'b1;
                end
                rsp_hit    <= lkt_rsp_hit;
                rsp_choice <= lkt_rsp_choice;
                rsp_result <= lkt_rsp_result;
            end
        end
    end

`ifdef LKT_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LOOKUPS; i++) begin
                if (grant_found && (grant_idx == TW'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
